// File: rtl/traffic_timer_pkg.sv
// ============================================================================
// Module      : traffic_timer_pkg
// Description : Shared constants and the state type for the interval timer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package traffic_timer_pkg;

  localparam int TIME_W = 4;

  localparam logic [1:0] INT_BASE = 2'd0;
  localparam logic [1:0] INT_EXT  = 2'd1;
  localparam logic [1:0] INT_YEL  = 2'd2;
  localparam logic [1:0] INT_WALK = 2'd3;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/time_param_regs.sv
// ============================================================================
// Module      : time_param_regs
// Description : Four 4-bit time parameters with reset defaults, zero-clamped
//               write port and combinational read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module time_param_regs
  import traffic_timer_pkg::*;
#(
  parameter int DEF_BASE = 6,
  parameter int DEF_EXT  = 3,
  parameter int DEF_YEL  = 2,
  parameter int DEF_WALK = 3
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              we,
  input  logic [1:0]        wsel,
  input  logic [TIME_W-1:0] wdata,
  input  logic [1:0]        rsel,
  output logic [TIME_W-1:0] rdata
);

  localparam logic [TIME_W-1:0] c_defaults [4] = '{
    TIME_W'(DEF_BASE), TIME_W'(DEF_EXT), TIME_W'(DEF_YEL), TIME_W'(DEF_WALK)
  };

  logic [TIME_W-1:0] r_param [4];
  logic [TIME_W-1:0] w_wdata;

  // A zero-length interval would never expire, so it is stored as 1.
  assign w_wdata = (wdata == '0) ? TIME_W'(1) : wdata;

  always_ff @(posedge clk) begin
    if (Reset) begin
      for (int i = 0; i < 4; i++) r_param[i] <= c_defaults[i];
    end else if (we) begin
      r_param[wsel] <= w_wdata;
    end
  end

  assign rdata = r_param[rsel];

endmodule

`default_nettype wire

// File: rtl/interval_timer.sv
// ============================================================================
// Module      : interval_timer
// Description : Loads a selected time parameter, counts it down on the 1 Hz
//               tick and pulses expired. INTERVAL_TIMER_PRESCALE_EN selects an
//               internal CLK_HZ prescaler instead of the oneHz_enable input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module interval_timer
  import traffic_timer_pkg::*;
#(
  parameter int CLK_HZ   = 100,
  parameter int DEF_BASE = 6,
  parameter int DEF_EXT  = 3,
  parameter int DEF_YEL  = 2,
  parameter int DEF_WALK = 3
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              oneHz_enable,
  input  logic              start_timer,
  input  logic [1:0]        interval,
  input  logic              Reprogram,
  input  logic [1:0]        Time_Parameter_Selector,
  input  logic [TIME_W-1:0] Time_Value,
  output logic              expired,
  output logic [TIME_W-1:0] value,
  output logic              busy
);

  logic              w_tick;
  logic [TIME_W-1:0] w_load;
  state_t            r_state;

  time_param_regs #(
    .DEF_BASE(DEF_BASE),
    .DEF_EXT (DEF_EXT),
    .DEF_YEL (DEF_YEL),
    .DEF_WALK(DEF_WALK)
  ) u_params (
    .clk  (clk),
    .Reset(Reset),
    .we   (Reprogram),
    .wsel (Time_Parameter_Selector),
    .wdata(Time_Value),
    .rsel (interval),
    .rdata(w_load)
  );

`ifdef INTERVAL_TIMER_PRESCALE_EN
  localparam int c_pre_w = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic [c_pre_w-1:0] r_pre;

  // Restarting on load keeps the first tick exactly CLK_HZ cycles away.
  always_ff @(posedge clk) begin
    if (Reset || Reprogram || start_timer || w_tick) r_pre <= '0;
    else                                           r_pre <= r_pre + 1'b1;
  end

  assign w_tick = (r_pre == c_pre_w'(CLK_HZ - 1));
`else
  assign w_tick = oneHz_enable;

  if (CLK_HZ < 1) begin : g_clk_hz_unused
  end
`endif

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      value   <= '0;
      busy    <= 1'b0;
      expired <= 1'b0;
    end else begin
      expired <= 1'b0;
      if (Reprogram) begin
        r_state <= ST_IDLE;
        value   <= '0;
        busy    <= 1'b0;
      end else if (start_timer) begin
        r_state <= ST_COUNT;
        value   <= w_load;
        busy    <= 1'b1;
      end else if (r_state == ST_COUNT && w_tick) begin
        if (value <= TIME_W'(1)) begin
          r_state <= ST_IDLE;
          value   <= '0;
          busy    <= 1'b0;
          expired <= 1'b1;
        end else begin
          value <= value - TIME_W'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_interval_timer.sv
// ============================================================================
// Module      : tb_interval_timer
// Description : Directed self-checking bench with a remaining-time model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_interval_timer;

  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic       oneHz_enable = 1'b0;
  logic       start_timer = 1'b0;
  logic [1:0] interval = '0;
  logic       Reprogram = 1'b0;
  logic [1:0] Time_Parameter_Selector = '0;
  logic [3:0] Time_Value = '0;
  logic       expired;
  logic [3:0] value;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;
  int n_exp    = 0;

  int m_param [4];
  int m_rem = 0;
  bit m_exp = 0;

  always #5 clk = ~clk;

  interval_timer dut (
    .clk                    (clk),
    .Reset                  (Reset),
    .oneHz_enable           (oneHz_enable),
    .start_timer            (start_timer),
    .interval               (interval),
    .Reprogram              (Reprogram),
    .Time_Parameter_Selector(Time_Parameter_Selector),
    .Time_Value             (Time_Value),
    .expired                (expired),
    .value                  (value),
    .busy                   (busy)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // One clock: apply inputs, advance the model by the rules, compare.
  task automatic cyc(input bit rst, input bit st, input int intv, input bit rp,
                     input int sel, input int tv, input bit tk);
    Reset = rst; start_timer = st; interval = 2'(intv);
    Reprogram = rp; Time_Parameter_Selector = 2'(sel);
    Time_Value = 4'(tv); oneHz_enable = tk;
    @(posedge clk);
    m_exp = 0;
    if (rst) begin
      m_param = '{6, 3, 2, 3};
      m_rem = 0;
    end else if (rp) begin
      m_param[sel] = (tv == 0) ? 1 : tv;
      m_rem = 0;
    end else if (st) begin
      m_rem = m_param[intv];
    end else if (tk && m_rem > 0) begin
      m_rem--;
      m_exp = (m_rem == 0);
    end
    #1;
    check("model_value", int'(value), m_rem);
    check("model_busy", int'(busy), int'(m_rem > 0));
    check("model_expired", int'(expired), int'(m_exp));
    if (expired) n_exp++;
  endtask

  task automatic nop(input bit tk);
    cyc(0, 0, 0, 0, 0, 0, tk);
  endtask

  task automatic start(input int intv, input bit tk);
    cyc(0, 1, intv, 0, 0, 0, tk);
  endtask

  task automatic reprog(input int sel, input int tv);
    cyc(0, 0, 0, 1, sel, tv, 0);
  endtask

  // Idle cycles with a tick on every 10th cycle.
  task automatic phase(input int ncyc);
    for (int k = 0; k < ncyc; k++) nop((k % 10) == 9);
  endtask

  initial begin
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    check("reset_value", int'(value), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_expired", int'(expired), 0);

    // Base interval with a tick every 10 cycles.
    start(0, 0);
    check("base_load", int'(value), 6);
    n_exp = 0;
    phase(60);
    check("base_expired_last", int'(expired), 1);
    check("base_expired_count", n_exp, 1);
    check("base_busy_after", int'(busy), 0);
    nop(0);
    check("base_expired_drop", int'(expired), 0);

    // Zero write clamps to 1.
    reprog(2, 0);
    start(2, 0);
    check("yel_clamp_load", int'(value), 1);
    nop(1);
    check("yel_first_tick_expired", int'(expired), 1);
    check("yel_first_tick_value", int'(value), 0);

    reprog(1, 9);
    start(1, 0);
    check("ext_load9", int'(value), 9);

    // Restart while busy.
    start(0, 0);
    nop(1);
    nop(1);
    check("restart_before", int'(value), 4);
    start(2, 0);
    check("restart_reload", int'(value), 1);
    n_exp = 0;
    phase(30);
    check("restart_expired_count", n_exp, 1);

    // Restore yellow to 2 and check the restart reloads 2.
    reprog(2, 2);
    start(0, 0);
    nop(1);
    nop(1);
    start(2, 0);
    check("restart_reload2", int'(value), 2);
    n_exp = 0;
    phase(30);
    check("restart2_expired_count", n_exp, 1);

    // Reprogram aborts a running count.
    start(0, 0);
    nop(1);
    reprog(3, 5);
    check("abort_value", int'(value), 0);
    check("abort_busy", int'(busy), 0);
    n_exp = 0;
    phase(20);
    check("abort_no_expired", n_exp, 0);

    // Start and tick together: tick ignored.
    start(1, 1);
    check("start_tick_same", int'(value), 9);

    // Start in the expired cycle.
    start(2, 0);
    nop(1);
    nop(1);
    check("exp_cycle_pulse", int'(expired), 1);
    start(0, 0);
    check("exp_cycle_start", int'(value), 6);
    check("exp_cycle_busy", int'(busy), 1);

    // Reset mid-count restores outputs and parameters.
    nop(1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    check("midreset_value", int'(value), 0);
    check("midreset_busy", int'(busy), 0);
    check("midreset_expired", int'(expired), 0);
    start(0, 0); check("def_base", int'(value), 6);
    start(1, 0); check("def_ext", int'(value), 3);
    start(2, 0); check("def_yel", int'(value), 2);
    start(3, 0); check("def_walk", int'(value), 3);
    phase(40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
